// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-ported register file with
// pending-write scoreboard.
package regfile_mp_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 32;
  localparam int unsigned DefaultNread = 2;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, packed read ports and reservation port.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned NREAD = DefaultNread
);
  localparam int unsigned AW = addr_width(DEPTH);

  logic                   write;
  logic [AW-1:0]          write_addr;
  logic [WIDTH-1:0]       write_data;
  logic [NREAD*AW-1:0]    read_addr;
  logic [NREAD*WIDTH-1:0] read_data;
  logic [NREAD-1:0]       read_busy;
  logic                   reserve;
  logic [AW-1:0]          reserve_addr;
  logic                   reserve_stall;
  logic [AW:0]            pending_count;

  modport master (
    output write, write_addr, write_data, read_addr, reserve, reserve_addr,
    input  read_data, read_busy, reserve_stall, pending_count
  );

  modport slave (
    input  write, write_addr, write_data, read_addr, reserve, reserve_addr,
    output read_data, read_busy, reserve_stall, pending_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits plus a running count of how many are set.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned AW = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [DEPTH-1:0] pending_o,
  output logic [AW:0]      pending_count_o
);

  localparam logic [AW:0] CountOne = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [AW:0]      count_q, count_d;
  logic             rise, fall;

  always_comb begin
    pending_d = pending_q;
    // Set after clear so a same-address write+reserve leaves the bit pending.
    if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
    if (set_en_i) pending_d[set_addr_i] = 1'b1;

    rise = set_en_i && !pending_q[set_addr_i];
    fall = clr_en_i && pending_q[clr_addr_i] && !(set_en_i && (set_addr_i == clr_addr_i));

    count_d = count_q;
    if (rise && !fall)      count_d = count_q + CountOne;
    else if (fall && !rise) count_d = count_q - CountOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o       = pending_q;
  assign pending_count_o = count_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass and a pending-write scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned DEPTH    = DefaultDepth,
  parameter int unsigned NREAD    = DefaultNread,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);

  localparam int unsigned AW = addr_width(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             write_en, reserve_req, reserve_ok, stall;
  logic [AW-1:0]    idx;
  logic             hit;

  // Writes and reservations are dead during reset and never touch register 0 when it is hardwired.
  always_comb begin
    write_en    = bus.write && !reset && !(ZERO_REG && (bus.write_addr == '0));
    reserve_req = bus.reserve && !reset && !(ZERO_REG && (bus.reserve_addr == '0));
    stall       = reserve_req && pending[bus.reserve_addr] &&
                  !(write_en && (bus.write_addr == bus.reserve_addr));
    reserve_ok  = reserve_req && !stall;
  end

  assign bus.reserve_stall = stall;

  always_comb begin
    regs_d = regs_q;
    if (write_en) regs_d[bus.write_addr] = bus.write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= WIDTH'(k);
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    bus.read_data = '0;
    bus.read_busy = '0;
    idx           = '0;
    hit           = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      idx = bus.read_addr[i*AW +: AW];
      hit = BYPASS && write_en && (bus.write_addr == idx);
      if (hit)                         bus.read_data[i*WIDTH +: WIDTH] = bus.write_data;
      else if (ZERO_REG && idx == '0)  bus.read_data[i*WIDTH +: WIDTH] = '0;
      else                             bus.read_data[i*WIDTH +: WIDTH] = regs_q[idx];
      bus.read_busy[i] = pending[idx] &&
                         !(hit && !(reserve_ok && (bus.reserve_addr == idx)));
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .set_en_i        (reserve_ok),
    .set_addr_i      (bus.reserve_addr),
    .clr_en_i        (write_en),
    .clr_addr_i      (bus.write_addr),
    .pending_o       (pending),
    .pending_count_o (bus.pending_count)
  );

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers (power of two, >= 2).
REQ-003 The block SHALL have parameter NREAD, default 2, meaning number of independent read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_REG, default 0, meaning that when 1, register 0 reads as zero, ignores writes and is never pending.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning that when 1, same-cycle write data is forwarded to matching read ports.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge active.
REQ-007 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port write, input, 1 bit, write enable.
REQ-009 The block SHALL have port write_addr, input, AW = log2(DEPTH) bits, write register index.
REQ-010 The block SHALL have port write_data, input, WIDTH bits, write value.
REQ-011 The block SHALL have port read_addr, input, NREAD*AW bits, packed read indices (port i at bits [i*AW +: AW]).
REQ-012 The block SHALL have port read_data, output, NREAD*WIDTH bits, packed read values.
REQ-013 The block SHALL have port read_busy, output, NREAD bits, set when the register addressed by port i has a pending write.
REQ-014 The block SHALL have port reserve, input, 1 bit, request to mark reserve_addr pending.
REQ-015 The block SHALL have port reserve_addr, input, AW bits, register index to reserve.
REQ-016 The block SHALL have port reserve_stall, output, 1 bit, reservation refused this cycle.
REQ-017 The block SHALL have port pending_count, output, AW+1 bits, number of pending registers.

Function
REQ-018 Reads SHALL be combinational: read_data[i] = registers[read_addr[i]], with zero latency.
REQ-019 When write=1, registers[write_addr] SHALL take write_data at the rising clk edge.
REQ-020 With BYPASS=1, write=1 and read_addr[i]==write_addr, read_data[i] SHALL equal write_data in the same cycle; with BYPASS=0 it SHALL show the old value.
REQ-021 With ZERO_REG=1, reads of index 0 SHALL return 0, bypass to index 0 SHALL be suppressed, and writes, reservations and pending state for index 0 SHALL be ignored (reserve_stall=0).
REQ-022 Each register SHALL have a pending bit; reserve=1 with a non-pending reserve_addr SHALL set that bit at the clk edge.
REQ-023 reserve_stall SHALL be combinational: 1 iff reserve=1 and reserve_addr is pending and not simultaneously being written; a stalled reservation SHALL change no state.
REQ-024 write=1 SHALL clear the pending bit of write_addr at the clk edge; writes to non-pending registers SHALL be legal and leave pending state unchanged.
REQ-025 Simultaneous write and reserve to the same address SHALL update the data, leave the pending bit set, and keep reserve_stall=0.
REQ-026 Simultaneous write and reserve to different addresses SHALL apply both updates independently.
REQ-027 read_busy[i] SHALL reflect the registered pending bit of read_addr[i], except that with BYPASS=1 it SHALL be 0 when that address is being written and not re-reserved this cycle.
REQ-028 pending_count SHALL be +1 on a reservation only, -1 on a clear only, unchanged on both or neither; it SHALL never wrap (max DEPTH, min 0).

Reset
REQ-029 While reset=1, asynchronously, every register k SHALL hold value k (zero-extended to WIDTH), all pending bits SHALL be 0 and pending_count SHALL be 0.
REQ-030 During reset, read_data SHALL show the index-valued contents, read_busy SHALL be 0 and reserve_stall SHALL be 0; write and reserve SHALL be ignored.
REQ-031 Reset asserted mid-operation SHALL discard all pending reservations and in-flight write data.

Structure
REQ-032 A shared package SHALL hold the default WIDTH/DEPTH/NREAD constants and the AW derivation function.
REQ-033 The pending-bit vector and pending_count SHALL live in one sub-module, regfile_scoreboard; data storage and bypass logic SHALL remain in regfile_mp.

Verification
REQ-034 Reset -> read_addr={5,31} gives read_data={5,31}, pending_count=0, read_busy=0.
REQ-035 write=1, write_addr=7, write_data=0xDEADBEEF, read_addr[0]=7, BYPASS=1 -> read_data[0]=0xDEADBEEF in the same cycle, and still after the edge.
REQ-036 Reserve 3, then reserve 3 again -> second cycle reserve_stall=1, pending_count stays 1; write 3 -> pending_count=0, read_busy=0.
REQ-037 Same cycle: write 9 (pending) and reserve 9 -> reserve_stall=0, data updated, 9 still pending, pending_count unchanged.
REQ-038 ZERO_REG=1: write 0 with 0x55, reserve 0 -> read_data=0, pending_count=0, reserve_stall=0.
REQ-039 Reserve all DEPTH registers, then assert reset mid-cycle asynchronously -> pending_count=DEPTH before reset, 0 immediately after, and registers reinitialised to their index values.
